atm_keypad_entry: RTL and testbench
===================================

// Module: atm_keypad_entry
// PURPOSE
//  Upstream front end of the ATM controller. Collects keypad digits into account number,
//  PIN, operation, amount and new PIN. Presents one complete transaction request to the
//  controller over a valid/ready handshake. Per-field digit counting and validation happen
//  here, so the controller only sees well-formed fields.
// PARAMETERS
//  AMT_DIGITS      6     max decimal digits accepted for amount (999999 < 2^32)
//  TIMEOUT_CYCLES  1000  idle cycles before abandoning entry (ATM_ENTRY_TIMEOUT_EN only)
// PORTS
//  clk        in   1   clock; all logic on posedge
//  rst        in   1   synchronous reset, active-high; single clock domain
//  key_valid  in   1   key_code valid this cycle (one key per asserted cycle)
//  key_code   in   4   0-9 digit, A ENTER, B CLEAR, C CANCEL, D-F ignored
//  req_ready  in   1   controller accepts request
//  req_valid  out  1   request fields complete and stable
//  acc_num    out  4   account index 0-9
//  pin        out  16  PIN, 4 BCD nibbles, first digit in [15:12]
//  new_pin    out  16  new PIN, same format; 0 unless CHANGE_PIN
//  amount     out  32  binary amount; 0 unless WITHDRAW/DEPOSIT
//  operation  out  3   `BALANCE/`WITHDRAW/`DEPOSIT/`CHANGE_PIN (definitions.v)
//  entry_err  out  1   1-cycle pulse: invalid ENTER or invalid key
//  timeout    out  1   1-cycle pulse: entry abandoned on inactivity
//  phase      out  3   current state encoding, for display
// BEHAVIOUR
//  Reset: all outputs 0, state S_ACC, digit count 0, timeout counter 0. Reset overrides all inputs.
//  States: S_ACC -> S_PIN -> S_OP -> {S_AMT | S_NEWPIN | S_HOLD} -> S_HOLD -> S_ACC.
//  Keys are sampled only when key_valid=1, with one state update per key.
//  Outputs are registered, so a field is visible the cycle after its ENTER.
//  Digit handling:
//   S_ACC: 1 digit. A second digit overwrites the first.
//   S_PIN / S_NEWPIN: field = {field[11:0], digit}. Digits beyond 4 are ignored and
//    pulse entry_err.
//   S_AMT: amount = amount*10 + digit. Digits beyond AMT_DIGITS are ignored and pulse entry_err.
//   S_OP: key 1 -> `BALANCE, 2 -> `WITHDRAW, 3 -> `DEPOSIT, 4 -> `CHANGE_PIN.
//    Other digits pulse entry_err and leave operation unchanged.
//  ENTER acceptance (otherwise entry_err pulses, the field is cleared, state is unchanged):
//   S_ACC: exactly 1 digit entered.
//   S_PIN / S_NEWPIN: exactly 4 digits entered.
//   S_OP: a valid op already selected.
//   S_AMT: >=1 digit entered and amount != 0.
//  S_OP ENTER routing: BALANCE -> S_HOLD, WITHDRAW/DEPOSIT -> S_AMT, CHANGE_PIN -> S_NEWPIN.
//  CLEAR: zero the current field and its digit count; stay in state.
//  CANCEL: zero all fields; go to S_ACC.
//  S_HOLD:
//   req_valid=1 and all fields frozen. All keys are ignored, CANCEL included.
//   On posedge with req_ready=1: req_valid<=0, all fields<=0, state<=S_ACC.
//   A key arriving in the same cycle as the handshake is dropped.
//  req_ready outside S_HOLD: ignored.
//  Keys D-F: ignored, with no error pulse.
// CONFIGURATION
//  ATM_ENTRY_TIMEOUT_EN defined:
//   Counter counts cycles with key_valid=0 in any state except S_HOLD and except S_ACC
//    with 0 digits.
//   Counter clears on any key_valid and on entry to S_HOLD.
//   At count == TIMEOUT_CYCLES-1: timeout pulses for 1 cycle, all fields clear, state -> S_ACC.
//   A key in that same cycle takes priority: it is processed and the counter clears.
//  ATM_ENTRY_TIMEOUT_EN undefined:
//   No counter; timeout is tied to 0.
//   TIMEOUT_CYCLES is unused.
// TESTING
//  1. Keys 3,A,1,2,3,4,A,1,A with req_ready=0 -> req_valid=1, acc_num=3, pin=16'h1234,
//     operation=`BALANCE, amount=0; held until req_ready=1, then all outputs 0 and phase=S_ACC.
//  2. Keys 5,A,9,9,9,9,A,2,A,2,5,0,A -> amount=250, operation=`WITHDRAW, req_valid=1.
//     Then hold req_ready=1 with key 7 in the same cycle -> request accepted, key dropped,
//     acc_num=0.
//  3. Keys 1,A,1,2,A -> entry_err pulse, pin cleared, phase=S_PIN.
//     Then 4,3,2,1,A -> phase=S_OP.
//  4. Op 4 path with new PIN keys 8,8,8,8,8 -> entry_err on the 5th digit, new_pin=16'h8888.
//     CANCEL mid-S_AMT -> all fields 0, phase=S_ACC.
//  5. With ATM_ENTRY_TIMEOUT_EN and TIMEOUT_CYCLES=8: enter acc 2, then idle 8 cycles ->
//     timeout pulses once, phase=S_ACC. Without the macro, timeout stays 0.
//  6. Assert rst in S_AMT with a key present -> next cycle all outputs 0, phase=S_ACC,
//     key ignored.

Source files
------------

// File: rtl/atm_keypad_entry_if.sv
// ATM keypad entry bus: keypad input, request handshake to the controller and
// display status, bundled for atm_keypad_entry.
//   master : the entry block (consumes keys and req_ready, drives the request)
//   slave  : the keypad/controller side
//   key_valid/key_code : one keypad key per asserted cycle
//   req_valid/req_ready: transaction request handshake
//   acc_num, pin, new_pin, amount, operation : request fields
//   entry_err, timeout : 1-cycle status pulses
//   phase              : current entry state, for display
interface atm_keypad_entry_if;
  logic        key_valid;
  logic [3:0]  key_code;
  logic        req_ready;
  logic        req_valid;
  logic [3:0]  acc_num;
  logic [15:0] pin;
  logic [15:0] new_pin;
  logic [31:0] amount;
  logic [2:0]  operation;
  logic        entry_err;
  logic        timeout;
  logic [2:0]  phase;

  modport master (
    input  key_valid, key_code, req_ready,
    output req_valid, acc_num, pin, new_pin, amount, operation, entry_err, timeout, phase
  );

  modport slave (
    output key_valid, key_code, req_ready,
    input  req_valid, acc_num, pin, new_pin, amount, operation, entry_err, timeout, phase
  );
endinterface

// File: rtl/atm_keypad_entry.sv
// atm_keypad_entry: keypad front end of the ATM controller. Collects account
// number, PIN, operation, amount and new PIN digit by digit, validates each field
// on ENTER and presents one complete request over a valid/ready handshake.
// Ports:
//   clk  : clock, all logic on posedge
//   rst  : synchronous active-high reset
//   bus  : atm_keypad_entry_if.master (keys in, request fields/status out)
// Parameters:
//   AMT_DIGITS     : max decimal digits accepted for the amount
//   TIMEOUT_CYCLES : idle cycles before entry is abandoned
// Build option:
//   ATM_ENTRY_TIMEOUT_EN : enables the inactivity timeout; otherwise timeout is 0.
// Operation codes: 1 BALANCE, 2 WITHDRAW, 3 DEPOSIT, 4 CHANGE_PIN, 0 none.
// Phase codes: 0 ACC, 1 PIN, 2 OP, 3 AMT, 4 NEWPIN, 5 HOLD.
module atm_keypad_entry #(
  parameter int unsigned AMT_DIGITS     = 6,
  parameter int unsigned TIMEOUT_CYCLES = 1000
) (
  input  logic               clk,
  input  logic               rst,
  atm_keypad_entry_if.master bus
);

  typedef enum logic [2:0] {
    S_ACC    = 3'd0,
    S_PIN    = 3'd1,
    S_OP     = 3'd2,
    S_AMT    = 3'd3,
    S_NEWPIN = 3'd4,
    S_HOLD   = 3'd5
  } state_e;

  localparam logic [2:0] OP_BALANCE    = 3'd1;
  localparam logic [2:0] OP_WITHDRAW   = 3'd2;
  localparam logic [2:0] OP_DEPOSIT    = 3'd3;
  localparam logic [2:0] OP_CHANGE_PIN = 3'd4;
  localparam logic [3:0] KEY_ENTER     = 4'hA;
  localparam logic [3:0] KEY_CLEAR     = 4'hB;
  localparam logic [3:0] KEY_CANCEL    = 4'hC;
  localparam logic [7:0] AMT_MAX       = 8'(AMT_DIGITS);

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [3:0]  acc_q, acc_d;
  logic [15:0] pin_q, pin_d;
  logic [15:0] new_pin_q, new_pin_d;
  logic [31:0] amount_q, amount_d;
  logic [2:0]  op_q, op_d;
  logic        req_valid_q, req_valid_d;
  logic        err_q, err_d;
  logic        to_q, to_d;
  logic        clear_all;
  logic        is_digit;

`ifdef ATM_ENTRY_TIMEOUT_EN
  localparam int unsigned      TMR_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);
  logic [TMR_W-1:0] tmr_q, tmr_d;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    pin_d     = pin_q;
    new_pin_d = new_pin_q;
    amount_d  = amount_q;
    op_d      = op_q;
    err_d     = 1'b0;
    to_d      = 1'b0;
    clear_all = 1'b0;
    is_digit  = (bus.key_code <= 4'd9);
`ifdef ATM_ENTRY_TIMEOUT_EN
    tmr_d     = '0;
`endif

    if (state_q == S_HOLD) begin
      // Fields stay frozen; only the handshake moves us on, keys are dropped.
      clear_all = bus.req_ready;
    end else if (bus.key_valid) begin
      if (is_digit) begin
        case (state_q)
          S_ACC: begin
            acc_d = bus.key_code;
            cnt_d = 8'd1;
          end
          S_PIN:
            if (cnt_q < 8'd4) begin
              pin_d = {pin_q[11:0], bus.key_code};
              cnt_d = cnt_q + 8'd1;
            end else err_d = 1'b1;
          S_NEWPIN:
            if (cnt_q < 8'd4) begin
              new_pin_d = {new_pin_q[11:0], bus.key_code};
              cnt_d     = cnt_q + 8'd1;
            end else err_d = 1'b1;
          S_AMT:
            if (cnt_q < AMT_MAX) begin
              amount_d = amount_q * 32'd10 + {28'd0, bus.key_code};
              cnt_d    = cnt_q + 8'd1;
            end else err_d = 1'b1;
          S_OP:
            if (bus.key_code >= 4'd1 && bus.key_code <= 4'd4) op_d = bus.key_code[2:0];
            else err_d = 1'b1;
          default: ;
        endcase
      end else if (bus.key_code == KEY_ENTER) begin
        cnt_d = '0;
        case (state_q)
          S_ACC:
            if (cnt_q == 8'd1) state_d = S_PIN;
            else begin
              err_d = 1'b1;
              acc_d = '0;
            end
          S_PIN:
            if (cnt_q == 8'd4) state_d = S_OP;
            else begin
              err_d = 1'b1;
              pin_d = '0;
            end
          S_OP:
            case (op_q)
              OP_BALANCE:              state_d = S_HOLD;
              OP_WITHDRAW, OP_DEPOSIT: state_d = S_AMT;
              OP_CHANGE_PIN:           state_d = S_NEWPIN;
              default:                 err_d   = 1'b1;
            endcase
          S_AMT:
            if (cnt_q != '0 && amount_q != '0) state_d = S_HOLD;
            else begin
              err_d    = 1'b1;
              amount_d = '0;
            end
          S_NEWPIN:
            if (cnt_q == 8'd4) state_d = S_HOLD;
            else begin
              err_d     = 1'b1;
              new_pin_d = '0;
            end
          default: ;
        endcase
      end else if (bus.key_code == KEY_CLEAR) begin
        cnt_d = '0;
        case (state_q)
          S_ACC:    acc_d     = '0;
          S_PIN:    pin_d     = '0;
          S_OP:     op_d      = '0;
          S_AMT:    amount_d  = '0;
          S_NEWPIN: new_pin_d = '0;
          default: ;
        endcase
      end else if (bus.key_code == KEY_CANCEL) begin
        clear_all = 1'b1;
      end
    end
`ifdef ATM_ENTRY_TIMEOUT_EN
    // Idle cycle; an empty account field means nothing to abandon yet.
    else if (!(state_q == S_ACC && cnt_q == '0)) begin
      if (tmr_q == TMR_LAST) begin
        to_d      = 1'b1;
        clear_all = 1'b1;
      end else begin
        tmr_d = tmr_q + 1'b1;
      end
    end
`endif

    if (clear_all) begin
      state_d   = S_ACC;
      cnt_d     = '0;
      acc_d     = '0;
      pin_d     = '0;
      new_pin_d = '0;
      amount_d  = '0;
      op_d      = '0;
    end

    req_valid_d = (state_d == S_HOLD);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_ACC;
      cnt_q       <= '0;
      acc_q       <= '0;
      pin_q       <= '0;
      new_pin_q   <= '0;
      amount_q    <= '0;
      op_q        <= '0;
      req_valid_q <= 1'b0;
      err_q       <= 1'b0;
      to_q        <= 1'b0;
`ifdef ATM_ENTRY_TIMEOUT_EN
      tmr_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      pin_q       <= pin_d;
      new_pin_q   <= new_pin_d;
      amount_q    <= amount_d;
      op_q        <= op_d;
      req_valid_q <= req_valid_d;
      err_q       <= err_d;
      to_q        <= to_d;
`ifdef ATM_ENTRY_TIMEOUT_EN
      tmr_q       <= tmr_d;
`endif
    end
  end

  assign bus.req_valid = req_valid_q;
  assign bus.acc_num   = acc_q;
  assign bus.pin       = pin_q;
  assign bus.new_pin   = new_pin_q;
  assign bus.amount    = amount_q;
  assign bus.operation = op_q;
  assign bus.entry_err = err_q;
  assign bus.timeout   = to_q;
  assign bus.phase     = state_q;

endmodule

// File: tb/tb_atm_keypad_entry.sv
// Testbench for atm_keypad_entry: directed scenarios plus randomized key traffic,
// compared every cycle against a digit-list model of the entry rules.
module tb_atm_keypad_entry;
  localparam int unsigned AMT_DIGITS     = 6;
  localparam int unsigned TIMEOUT_CYCLES = 8;
  localparam int PH_ACC = 0, PH_PIN = 1, PH_OP = 2, PH_AMT = 3, PH_NEWPIN = 4, PH_HOLD = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;

  atm_keypad_entry_if bus ();

  atm_keypad_entry #(
    .AMT_DIGITS    (AMT_DIGITS),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Model: each field is the list of digits typed into it.
  int m_ph = PH_ACC;
  int q_acc[$];
  int q_pin[$];
  int q_amt[$];
  int q_np[$];
  int m_op   = 0;
  bit m_err  = 1'b0;
  bit m_to   = 1'b0;
  int m_idle = 0;

  function automatic logic [31:0] digits_hex(input int q[$]);
    logic [31:0] v = '0;
    foreach (q[i]) v = (v << 4) | 32'(q[i]);
    return v;
  endfunction

  function automatic logic [31:0] digits_dec(input int q[$]);
    longint v = 0;
    foreach (q[i]) v = v * 10 + q[i];
    return 32'(v);
  endfunction

  function automatic logic [31:0] e_acc();
    return (q_acc.size() != 0) ? 32'(q_acc[0]) : 32'd0;
  endfunction

  task automatic m_clear_all();
    m_ph = PH_ACC;
    q_acc.delete();
    q_pin.delete();
    q_amt.delete();
    q_np.delete();
    m_op   = 0;
    m_idle = 0;
  endtask

  task automatic m_key(input int k);
    if (k <= 9) begin
      case (m_ph)
        PH_ACC:    begin q_acc.delete(); q_acc.push_back(k); end
        PH_PIN:    if (q_pin.size() < 4) q_pin.push_back(k); else m_err = 1'b1;
        PH_NEWPIN: if (q_np.size() < 4) q_np.push_back(k); else m_err = 1'b1;
        PH_AMT:    if (q_amt.size() < int'(AMT_DIGITS)) q_amt.push_back(k); else m_err = 1'b1;
        PH_OP:     if (k >= 1 && k <= 4) m_op = k; else m_err = 1'b1;
        default: ;
      endcase
    end else if (k == 10) begin
      case (m_ph)
        PH_ACC:    if (q_acc.size() == 1) m_ph = PH_PIN; else begin m_err = 1'b1; q_acc.delete(); end
        PH_PIN:    if (q_pin.size() == 4) m_ph = PH_OP; else begin m_err = 1'b1; q_pin.delete(); end
        PH_OP:     if (m_op == 0) m_err = 1'b1;
                   else m_ph = (m_op == 1) ? PH_HOLD : (m_op == 4) ? PH_NEWPIN : PH_AMT;
        PH_AMT:    if (digits_dec(q_amt) != 0) m_ph = PH_HOLD; else begin m_err = 1'b1; q_amt.delete(); end
        PH_NEWPIN: if (q_np.size() == 4) m_ph = PH_HOLD; else begin m_err = 1'b1; q_np.delete(); end
        default: ;
      endcase
    end else if (k == 11) begin
      case (m_ph)
        PH_ACC:    q_acc.delete();
        PH_PIN:    q_pin.delete();
        PH_OP:     m_op = 0;
        PH_AMT:    q_amt.delete();
        PH_NEWPIN: q_np.delete();
        default: ;
      endcase
    end else if (k == 12) begin
      m_clear_all();
    end
  endtask

  task automatic m_step(input bit r, input bit kv, input int k, input bit rr);
    m_err = 1'b0;
    m_to  = 1'b0;
    if (r) m_clear_all();
    else if (m_ph == PH_HOLD) begin
      if (rr) m_clear_all();
    end else if (kv) begin
      m_idle = 0;
      m_key(k);
    end else if (m_ph == PH_ACC && q_acc.size() == 0) begin
      m_idle = 0;
    end else begin
`ifdef ATM_ENTRY_TIMEOUT_EN
      m_idle++;
      if (m_idle == int'(TIMEOUT_CYCLES)) begin
        m_to = 1'b1;
        m_clear_all();
      end
`endif
    end
  endtask

  always @(posedge clk) m_step(rst, bus.key_valid, int'(bus.key_code), bus.req_ready);

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
  endtask

  // Literal expectation applied to both the DUT and the model.
  task automatic lit(input string name, input logic [31:0] dut_v, input logic [31:0] mdl_v,
                     input logic [31:0] exp);
    chk({name, " dut"}, dut_v, exp);
    chk({name, " model"}, mdl_v, exp);
  endtask

  always @(negedge clk) begin
    chk("req_valid", 32'(bus.req_valid), 32'(m_ph == PH_HOLD));
    chk("acc_num",   32'(bus.acc_num),   e_acc());
    chk("pin",       32'(bus.pin),       digits_hex(q_pin));
    chk("new_pin",   32'(bus.new_pin),   digits_hex(q_np));
    chk("amount",    bus.amount,         digits_dec(q_amt));
    chk("operation", 32'(bus.operation), 32'(m_op));
    chk("entry_err", 32'(bus.entry_err), 32'(m_err));
    chk("timeout",   32'(bus.timeout),   32'(m_to));
    chk("phase",     32'(bus.phase),     32'(m_ph));
  end

  task automatic step(input bit r, input bit kv, input logic [3:0] kc, input bit rr);
    rst           = r;
    bus.key_valid = kv;
    bus.key_code  = kc;
    bus.req_ready = rr;
    @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [3:0] k);
    step(1'b0, 1'b1, k, 1'b0);
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 1'b0, 4'h0, 1'b0);
  endtask

  task automatic keys(input string s);
    for (int i = 0; i < s.len(); i++) begin
      byte c;
      c = s[i];
      press((c <= "9") ? 4'(c - 8'd48) : 4'(c - 8'd55));
    end
  endtask

  task automatic gpress(input logic [3:0] k);
    idle($urandom_range(0, 2));
    press(k);
  endtask

  task automatic valid_txn();
    int op;
    if (m_ph == PH_HOLD) step(1'b0, 1'b0, 4'h0, 1'b1);
    gpress(4'hC);
    gpress(4'($urandom_range(0, 9)));
    gpress(4'hA);
    repeat (4) gpress(4'($urandom_range(0, 9)));
    gpress(4'hA);
    op = $urandom_range(1, 4);
    gpress(4'(op));
    gpress(4'hA);
    if (op == 2 || op == 3) begin
      gpress(4'($urandom_range(1, 9)));
      repeat ($urandom_range(0, 5)) gpress(4'($urandom_range(0, 9)));
      gpress(4'hA);
    end else if (op == 4) begin
      repeat (4) gpress(4'($urandom_range(0, 9)));
      gpress(4'hA);
    end
    idle($urandom_range(0, 3));
    step(1'b0, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 1'b1);
  endtask

  task automatic noise(input int n);
    repeat (n) begin
      int r;
      logic [3:0] kc;
      r = $urandom_range(0, 18);
      if (r < 10)       kc = 4'(r);
      else if (r < 14)  kc = 4'hA;
      else if (r == 14) kc = 4'hB;
      else if (r == 15) kc = 4'hC;
      else              kc = 4'(r - 3);
      step(1'($urandom_range(0, 199) == 0), 1'($urandom_range(0, 9) < 6), kc,
           1'($urandom_range(0, 3) == 0));
    end
  endtask

  initial begin
    bus.key_valid = 1'b0;
    bus.key_code  = 4'h0;
    bus.req_ready = 1'b0;
    step(1'b1, 1'b0, 4'h0, 1'b0);
    step(1'b1, 1'b0, 4'h0, 1'b0);
    lit("reset phase", 32'(bus.phase), 32'(m_ph), 32'd0);
    lit("reset req_valid", 32'(bus.req_valid), 32'(m_ph == PH_HOLD), 32'd0);
    idle(1);

    // Balance request held until accepted
    keys("3A1234A1A");
    lit("t1 req_valid", 32'(bus.req_valid), 32'(m_ph == PH_HOLD), 32'd1);
    lit("t1 acc", 32'(bus.acc_num), e_acc(), 32'd3);
    lit("t1 pin", 32'(bus.pin), digits_hex(q_pin), 32'h1234);
    lit("t1 op", 32'(bus.operation), 32'(m_op), 32'd1);
    lit("t1 amount", bus.amount, digits_dec(q_amt), 32'd0);
    idle(3);
    lit("t1 held", 32'(bus.req_valid), 32'(m_ph == PH_HOLD), 32'd1);
    step(1'b0, 1'b0, 4'h0, 1'b1);
    lit("t1 accepted", 32'(bus.req_valid), 32'(m_ph == PH_HOLD), 32'd0);
    lit("t1 pin clr", 32'(bus.pin), digits_hex(q_pin), 32'd0);
    lit("t1 phase", 32'(bus.phase), 32'(m_ph), 32'd0);

    // Withdraw 250, key during handshake dropped
    keys("5A9999A2A250A");
    lit("t2 amount", bus.amount, digits_dec(q_amt), 32'd250);
    lit("t2 op", 32'(bus.operation), 32'(m_op), 32'd2);
    lit("t2 req_valid", 32'(bus.req_valid), 32'(m_ph == PH_HOLD), 32'd1);
    step(1'b0, 1'b1, 4'h7, 1'b1);
    lit("t2 accepted", 32'(bus.req_valid), 32'(m_ph == PH_HOLD), 32'd0);
    lit("t2 acc", 32'(bus.acc_num), e_acc(), 32'd0);
    idle(1);

    // Short PIN rejected
    keys("1A12A");
    lit("t3 err", 32'(bus.entry_err), 32'(m_err), 32'd1);
    lit("t3 pin", 32'(bus.pin), digits_hex(q_pin), 32'd0);
    lit("t3 phase", 32'(bus.phase), 32'(m_ph), 32'd1);
    keys("4321A");
    lit("t3 phase op", 32'(bus.phase), 32'(m_ph), 32'd2);

    // New PIN overflow, amount overflow, CANCEL in amount
    keys("4A8888");
    press(4'h8);
    lit("t4 err", 32'(bus.entry_err), 32'(m_err), 32'd1);
    lit("t4 new_pin", 32'(bus.new_pin), digits_hex(q_np), 32'h8888);
    keys("C6A1111A3A1234567");
    lit("t4 amt err", 32'(bus.entry_err), 32'(m_err), 32'd1);
    lit("t4 amount", bus.amount, digits_dec(q_amt), 32'd123456);
    press(4'hC);
    lit("t4 cancel amount", bus.amount, digits_dec(q_amt), 32'd0);
    lit("t4 cancel pin", 32'(bus.pin), digits_hex(q_pin), 32'd0);
    lit("t4 cancel phase", 32'(bus.phase), 32'(m_ph), 32'd0);

    // Reset in S_AMT with a key present
    keys("7A2222A2A35");
    step(1'b1, 1'b1, 4'h5, 1'b0);
    lit("t6 amount", bus.amount, digits_dec(q_amt), 32'd0);
    lit("t6 acc", 32'(bus.acc_num), e_acc(), 32'd0);
    lit("t6 phase", 32'(bus.phase), 32'(m_ph), 32'd0);
    idle(1);

    // Inactivity after an account digit
    press(4'h2);
    for (int i = 0; i < 8; i++) begin
      logic [31:0] exp_to;
`ifdef ATM_ENTRY_TIMEOUT_EN
      exp_to = (i == 7) ? 32'd1 : 32'd0;
`else
      exp_to = 32'd0;
`endif
      idle(1);
      lit("t5 timeout", 32'(bus.timeout), 32'(m_to), exp_to);
    end
    press(4'hB);

    for (int ep = 0; ep < 60; ep++) begin
      if ($urandom_range(0, 2) != 0) valid_txn();
      else noise(25);
    end
    idle(2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
